// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO. It pops the FIFO, absorbs the one-cycle read
// latency, and presents the words as a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_r_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  flush,
   output logic [CNT_WIDTH-1:0]  rd_count
);

   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic                  drop_q, drop_d;
   logic                  head_q, head_d;
   logic                  tail_q, tail_d;
   logic [DATA_WIDTH-1:0] mem_q [2];
   logic [DATA_WIDTH-1:0] mem_d [2];
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;

   logic                  pop;
   logic                  cap;
   logic [2:0]            committed;

   always_comb begin
      pop       = (occ_q != 2'd0) & m_ready;
      cap       = inflight_q & ~drop_q & ~flush;
      // Words buffered or in flight that will still be held after this cycle's handshake.
      committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
      fifo_r_en = rrst_n & ~flush & ~fifo_empty & (committed < 3'd2);

      occ_d      = occ_q;
      head_d     = head_q;
      tail_d     = tail_q;
      mem_d      = mem_q;
      inflight_d = fifo_r_en;
      drop_d     = flush & inflight_q;
      rd_count_d = rd_count_q + CNT_WIDTH'(pop);

      if (flush) begin
         occ_d  = '0;
         head_d = 1'b0;
         tail_d = 1'b0;
      end else begin
         if (cap) begin
            mem_d[tail_q] = fifo_data_out;
            tail_d        = ~tail_q;
         end
         head_d = head_q ^ pop;
         occ_d  = occ_q + {1'b0, cap} - {1'b0, pop};
      end

      // Output word is registered so it holds its last value once the buffer drains.
      m_data_d = (occ_d != 2'd0) ? mem_d[head_d] : m_data_q;
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         occ_q      <= '0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         m_data_q   <= '0;
         rd_count_q <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         mem_q      <= mem_d;
         m_data_q   <= m_data_d;
         rd_count_q <= rd_count_d;
      end
   end

   assign m_valid  = (occ_q != 2'd0);
   assign m_data   = m_data_q;
   assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based delivery model checked every cycle, plus
// directed scenarios with literal expectations on the delivered word log.
module tb_fifo_rd_stream;

   logic        rclk = 1'b0;
   logic        rrst_n;
   logic        fifo_empty;
   logic [7:0]  fifo_data_out = 8'h00;
   logic        fifo_r_en;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        flush;
   logic [15:0] rd_count;

   fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
      .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .flush(flush), .rd_count(rd_count)
   );

   always #5 rclk = ~rclk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Behavioural FIFO source: a 1-cycle-latency read port over a circular store.
   logic [7:0] fmem [256];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge rclk) begin
      if (fifo_r_en && !fifo_empty) begin
         fifo_data_out <= fmem[rd_ptr[7:0]];
         rd_ptr        <= rd_ptr + 1;
      end else begin
         fifo_data_out <= 8'($urandom);
      end
   end

   task automatic push(input logic [7:0] d);
      fmem[wr_ptr[7:0]] = d;
      wr_ptr++;
   endtask

   // Model: every word taken from the FIFO is owed to the consumer in order, becoming
   // visible two cycles after its pop; flush forgets all owed words, reset forgets everything.
   logic [7:0]  eq_d [$];
   int          eq_t [$];
   logic [7:0]  last_d = 8'h00;
   logic [15:0] cnt = 16'h0000;
   int          cyc = 0;
   bit          chk_en = 1'b0;
   int          ren_cnt = 0;
   logic [7:0]  dlog_d [$];
   int          dlog_c [$];

   always @(negedge rclk) begin
      logic       ev;
      logic [7:0] ed;
      logic       pop_m;
      logic       exp_ren;
      ev      = (eq_d.size() != 0) && (eq_t[0] <= cyc);
      ed      = ev ? eq_d[0] : last_d;
      pop_m   = ev && m_ready;
      exp_ren = rrst_n && !flush && !fifo_empty && ((int'(eq_d.size()) - int'(pop_m)) < 2);
      if (!rrst_n) chk("ren_in_reset", {31'd0, fifo_r_en}, 32'd0);
      if (chk_en) begin
         chk("m_valid", {31'd0, m_valid}, {31'd0, ev});
         chk("m_data", {24'd0, m_data}, {24'd0, ed});
         chk("rd_count", {16'd0, rd_count}, {16'd0, cnt});
         chk("fifo_r_en", {31'd0, fifo_r_en}, {31'd0, exp_ren});
         chk("occ_bound", {31'd0, (dut.occ_q <= 2'd2)}, 32'd1);
      end
      if (rrst_n && fifo_r_en) ren_cnt++;
      if (!rrst_n) begin
         eq_d.delete();
         eq_t.delete();
         cnt    = 16'h0000;
         last_d = 8'h00;
         chk_en = 1'b1;
      end else begin
         if (ev) last_d = ed;
         if (pop_m) begin
            dlog_d.push_back(m_data);
            dlog_c.push_back(cyc);
            void'(eq_d.pop_front());
            void'(eq_t.pop_front());
            cnt = cnt + 16'd1;
         end
         if (fifo_r_en && !fifo_empty) begin
            eq_d.push_back(fmem[rd_ptr[7:0]]);
            eq_t.push_back(cyc + 2);
         end
         if (flush) begin
            eq_d.delete();
            eq_t.delete();
         end
      end
      cyc++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge rclk);
      #1;
   endtask

   task automatic clear_log();
      dlog_d.delete();
      dlog_c.delete();
   endtask

   // Compares the delivered log against a literal sequence first, first+1, ...; optionally
   // demands back-to-back delivery.
   task automatic check_seq(input string nm, input logic [7:0] first, input int n,
                            input bit b2b);
      chk({nm, "_len"}, dlog_d.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < dlog_d.size()) begin
            chk({nm, "_data"}, {24'd0, dlog_d[i]}, {24'd0, first + 8'(i)});
            if (b2b) chk({nm, "_b2b"}, dlog_c[i], dlog_c[0] + i);
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rel;
      int pushed;
      rrst_n  = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b0;

      // 1: preloaded 0x11,0x22,0x33, first word visible two cycles after release
      push(8'h11); push(8'h22); push(8'h33);
      tick(3);
      m_ready = 1'b1;
      rrst_n  = 1'b1;
      rel     = cyc;
      clear_log();
      ren_cnt = 0;
      tick(8);
      chk("t1_len", dlog_d.size(), 3);
      if (dlog_d.size() == 3) begin
         chk("t1_first_cyc", dlog_c[0], rel + 2);
         chk("t1_cyc1", dlog_c[1], rel + 3);
         chk("t1_cyc2", dlog_c[2], rel + 4);
         chk("t1_w0", {24'd0, dlog_d[0]}, 32'h11);
         chk("t1_w1", {24'd0, dlog_d[1]}, 32'h22);
         chk("t1_w2", {24'd0, dlog_d[2]}, 32'h33);
      end
      chk("t1_rd_count", {16'd0, rd_count}, 32'd3);
      chk("t1_ren_cycles", ren_cnt, 3);

      // 2: ten words streamed without bubbles
      clear_log();
      for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
      tick(16);
      check_seq("t2", 8'hA0, 10, 1'b1);
      chk("t2_rd_count", {16'd0, rd_count}, 32'd13);

      // 3: backpressure holds two words, then drains in order
      m_ready = 1'b0;
      clear_log();
      ren_cnt = 0;
      for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
      tick(8);
      chk("t3_pops", ren_cnt, 2);
      chk("t3_valid", {31'd0, m_valid}, 32'd1);
      chk("t3_hold", {24'd0, m_data}, 32'h50);
      chk("t3_occ", {30'd0, dut.occ_q}, 32'd2);
      m_ready = 1'b1;
      tick(10);
      check_seq("t3", 8'h50, 5, 1'b1);
      chk("t3_rd_count", {16'd0, rd_count}, 32'd18);

      // 4: flush with one word buffered and one in flight
      m_ready = 1'b0;
      clear_log();
      for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
      tick(2);
      chk("t4_pre_data", {24'd0, m_data}, 32'h60);
      flush = 1'b1;
      #1;
      chk("t4_flush_ren", {31'd0, fifo_r_en}, 32'd0);
      tick(1);
      flush = 1'b0;
      chk("t4_valid_after", {31'd0, m_valid}, 32'd0);
      chk("t4_rd_count_kept", {16'd0, rd_count}, 32'd18);
      m_ready = 1'b1;
      tick(10);
      check_seq("t4", 8'h62, 4, 1'b1);
      chk("t4_rd_count", {16'd0, rd_count}, 32'd22);

      // 6: reset while two words are buffered
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
      tick(5);
      chk("t6_occ", {30'd0, dut.occ_q}, 32'd2);
      rrst_n = 1'b0;
      #1;
      chk("t6_ren_reset", {31'd0, fifo_r_en}, 32'd0);
      tick(1);
      chk("t6_valid", {31'd0, m_valid}, 32'd0);
      chk("t6_data", {24'd0, m_data}, 32'd0);
      chk("t6_rd_count", {16'd0, rd_count}, 32'd0);
      tick(1);
      rrst_n  = 1'b1;
      m_ready = 1'b1;
      clear_log();
      tick(8);
      check_seq("t6", 8'h72, 2, 1'b1);
      chk("t6_rd_count_after", {16'd0, rd_count}, 32'd2);

      // 5: run the counter up to its wrap point
      pushed = 0;
      for (int c = 0; c < 70000 && pushed < 65533; c++) begin
         if (wr_ptr - rd_ptr < 4) begin
            push(8'(pushed));
            pushed++;
         end
         tick(1);
      end
      tick(8);
      chk("t5_ffff", {16'd0, rd_count}, 32'h0000FFFF);
      push(8'h5A);
      tick(6);
      chk("t5_wrap0", {16'd0, rd_count}, 32'h00000000);
      push(8'hA5);
      tick(6);
      chk("t5_wrap1", {16'd0, rd_count}, 32'h00000001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
